bus_arbiter_4way: RTL and testbench

Round-robin arbiter for the four-source shared bus. It takes requests from four sources and produces a one-hot grant. It also produces the 2-bit select `sel` and the `busy` qualifier consumed directly by the downstream 4-way bus multiplexer. The bus owner is held while it keeps requesting, with an optional hold limit to guarantee fairness.

---
 rtl/bus_arbiter_4way_if.sv | 20 ++
 rtl/bus_arbiter_4way.sv | 175 +++++++++++++++++
 tb/tb_bus_arbiter_4way.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_4way_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_4way_if
// Handshake bundle between the four bus sources and the 4-way arbiter.
//   req  [3:0] : level request from each source, held high for the transfer
//   gnt  [3:0] : one-hot grant, all-zero when the bus is idle
//   sel  [1:0] : binary index of the current owner (mux select)
//   busy       : high while any grant is active (mux output qualifier)
// Modports:
//   master : arbiter side, drives gnt/sel/busy and samples req
//   slave  : source/mux side, drives req and observes gnt/sel/busy
// ---------------------------------------------------------------------------
interface bus_arbiter_4way_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  modport master (input req, output gnt, output sel, output busy);
  modport slave  (output req, input gnt, input sel, input busy);
endinterface

// File: rtl/bus_arbiter_4way.sv
// ---------------------------------------------------------------------------
// bus_arbiter_4way
// Round-robin arbiter for the four-source shared bus. The owner keeps the
// bus while it requests; when it drops its request the next requester is
// granted on the same edge (no dead cycle). All outputs are registered.
//
// Parameters:
//   MAX_HOLD : max consecutive granted cycles while others wait (2..256),
//              only meaningful when ARB_HOLD_LIMIT_EN is defined.
// Ports:
//   clk  : system clock, rising-edge
//   rst  : asynchronous active-high reset
//   bus  : bus_arbiter_4way_if.master (req in; gnt, sel, busy out)
// Build option:
//   ARB_HOLD_LIMIT_EN : when defined, a hold counter preempts an owner after
//                       MAX_HOLD cycles if any other source is requesting.
// ---------------------------------------------------------------------------
module bus_arbiter_4way #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_arbiter_4way_if.master    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Reject out-of-range configurations at elaboration time.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 256)) begin : g_bad_max_hold
    $error("bus_arbiter_4way: MAX_HOLD must be in 2..256");
  end

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic [1:0] ptr_q, ptr_d;

  logic [3:0] others_s;
  logic [2:0] win_all_s;
  logic [2:0] win_oth_s;
  logic       grant_s;
  logic [1:0] win_s;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Round-robin search starting at p: returns {found, index}. Scanning the
  // offsets downwards lets the smallest offset from p overwrite the result.
  function automatic logic [2:0] rr_search(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    grant_s = 1'b0;
    win_s   = 2'b00;

    // In OWN, gnt_q is one-hot of the owner, so this masks the owner out.
    others_s  = bus.req & ~gnt_q;
    win_all_s = rr_search(bus.req, ptr_q);
    win_oth_s = rr_search(others_s, ptr_q);

    case (state_q)
      IDLE: begin
        if (win_all_s[2]) begin
          grant_s = 1'b1;
          win_s   = win_all_s[1:0];
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!bus.req[sel_q]) begin
          if (win_oth_s[2]) begin
            // Direct handover, no idle cycle between owners.
            grant_s = 1'b1;
            win_s   = win_oth_s[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
          end
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
          if (cnt_q == CNT_MAX) begin
            // Forced release only under contention; otherwise saturate.
            if (win_oth_s[2]) begin
              grant_s = 1'b1;
              win_s   = win_oth_s[1:0];
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          state_d = OWN;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase

    if (grant_s) begin
      state_d = OWN;
      gnt_d   = 4'b0001 << win_s;
      sel_d   = win_s;
      busy_d  = 1'b1;
      ptr_d   = win_s + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_d   = '0;
`endif
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State, pointer and registered outputs with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      ptr_q   <= 2'b00;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter_4way.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_4way
// Scoreboard bench for bus_arbiter_4way (MAX_HOLD=4). Each driven request
// vector pushes the reference model's expected outputs to a queue; after the
// clock edge the entry is popped and compared with the DUT. Directed steps
// additionally compare gnt against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_4way;
  localparam int MAXH = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  bus_arbiter_4way_if bus_if();

  bus_arbiter_4way #(.MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  bit         m_own;
  int         m_ptr;
  int         m_cnt;
  int         m_sel;
  logic [3:0] m_gnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = 1'b0; m_ptr = 0; m_cnt = 0; m_sel = 0; m_gnt = 4'b0000;
  endtask

  task automatic model_grant(input int w);
    m_own = 1'b1;
    m_gnt = 4'b0001 << w;
    m_sel = w;
    m_cnt = 0;
    m_ptr = (w + 1) % 4;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    int w;
    if (!m_own) begin
      w = pick(r, m_ptr);
      if (w >= 0) model_grant(w);
    end else begin
      oth = r;
      oth[m_sel] = 1'b0;
      if (!r[m_sel]) begin
        if (oth != 4'b0000) model_grant(pick(oth, m_ptr));
        else begin m_own = 1'b0; m_gnt = 4'b0000; end
      end else if (HOLD_EN && (m_cnt == MAXH - 1) && (oth != 4'b0000)) begin
        model_grant(pick(oth, m_ptr));
      end else if (m_cnt < MAXH - 1) begin
        m_cnt++;
      end
    end
  endtask

  // Drive one request vector for one clock; exp_gnt < 0 means model only.
  task automatic step(input logic [3:0] r, input int exp_gnt, input string tag);
    exp_t e;
    bus_if.req = r;
    model_step(r);
    e.gnt  = m_gnt;
    e.sel  = m_sel[1:0];
    e.busy = m_own;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, "/gnt"},  bus_if.gnt,  e.gnt);
    check_eq({tag, "/sel"},  bus_if.sel,  e.sel);
    check_eq({tag, "/busy"}, bus_if.busy, e.busy);
    if (exp_gnt >= 0) check_eq({tag, "/plan"}, bus_if.gnt, exp_gnt[3:0]);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.req = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset/gnt",  bus_if.gnt,  4'b0000);
    check_eq("reset/sel",  bus_if.sel,  2'b00);
    check_eq("reset/busy", bus_if.busy, 1'b0);
    rst = 1'b0;

    // Single requester for 3 cycles, then release
    for (int i = 0; i < 3; i++) step(4'b0010, 2, "single");
    step(4'b0000, 0, "single_rel");

    // Pointer wrap after a grant to source 3
    step(4'b1000, 8, "wrap_g3");
    step(4'b0000, 0, "wrap_rel");
    step(4'b1001, 1, "wrap");
    step(4'b0000, 0, "wrap_rel2");

    // Asynchronous reset while source 2 owns the bus
    step(4'b0100, 4, "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    check_eq("rst_async/gnt",  bus_if.gnt,  4'b0000);
    check_eq("rst_async/sel",  bus_if.sel,  2'b00);
    check_eq("rst_async/busy", bus_if.busy, 1'b0);
    bus_if.req = 4'b1111;
    @(posedge clk);
    #1;
    check_eq("rst_hold/gnt", bus_if.gnt, 4'b0000);
    rst = 1'b0;
    model_reset();
    step(4'b1111, 1, "rst_first");

    // Round-robin: each owner holds 2 cycles then drops for one cycle
    step(4'b1111, 1, "rr0");
    step(4'b1110, 2, "rr1");
    step(4'b1111, 2, "rr1b");
    step(4'b1101, 4, "rr2");
    step(4'b1111, 4, "rr2b");
    step(4'b1011, 8, "rr3");
    step(4'b1111, 8, "rr3b");
    step(4'b0111, 1, "rr0_again");
    step(4'b0000, 0, "rr_rel");

    // Hold limit: source 0 continuous, source 2 joins on the next cycle
    step(4'b0001, 1, "hold_start");
    for (int i = 0; i < 6; i++)
      step(4'b0101, (HOLD_EN && i >= 3) ? 4 : 1, "hold");
    step(4'b0000, 0, "hold_rel");

    // No contention: a lone owner is never preempted
    for (int i = 0; i < 10; i++) step(4'b0010, 2, "lone");
    step(4'b0000, 0, "lone_rel");

    // Random requests checked against the model
    for (int i = 0; i < 60; i++) step(4'($urandom_range(0, 15)), -1, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
